// File: rtl/dut_response_capture.sv
`timescale 1ns/1ps
// dut_response_capture: samples synchronised DUT pins at a programmable strobe
// tick, compares them against double-buffered expected data gated by mask and
// template, and accumulates sticky per-pin fails plus a saturating fail count.
module dut_response_capture #(
    parameter int WIDTH  = 126,
    parameter int FCNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PERFORM_TEST,
    input  logic [WIDTH-1:0]  BUS126,
    input  logic              EXP_LOAD,
    input  logic              EXP_TRANSFER,
    input  logic              MASK_LOAD,
    input  logic              MASK_TRANSFER,
    input  logic [6:0]        STROBE_EDGE,
    input  logic [7:0]        CYCLE_LENGTH,
    input  logic [WIDTH-1:0]  TEMPLATE,
    input  logic [WIDTH-1:0]  DUT_SIGNALS,
    input  logic              CLEAR_FAILS,
    output logic [WIDTH-1:0]  CAPTURED,
    output logic [WIDTH-1:0]  FAIL_VECTOR,
    output logic              FAIL,
    output logic [FCNT_W-1:0] FAIL_COUNT,
    output logic              CYCLE_DONE,
    output logic              STROBE_ERR,
    output logic              BUSY
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (&v) ? v : v + {{(FCNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         tick_q, tick_d;
    logic [WIDTH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0]   exp_sh_q, exp_sh_d, exp_act_q, exp_act_d;
    logic [WIDTH-1:0]   mask_sh_q, mask_sh_d, mask_act_q, mask_act_d;
    logic [WIDTH-1:0]   cap_q, cap_d, exp_snap_q, exp_snap_d, en_snap_q, en_snap_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic [WIDTH-1:0]   fvec_q, fvec_d;
    logic               fail_q, fail_d, serr_q, serr_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [WIDTH-1:0]   mism;
    logic [8:0]         len, last_tick;
    logic               at_last, se_late, strobe, cycle_done, serr_set;

    // Cycle length of 0 encodes 256 ticks; both compares use live inputs.
    assign len       = (CYCLE_LENGTH == 8'd0) ? 9'd256 : {1'b0, CYCLE_LENGTH};
    assign last_tick = len - 9'd1;
    assign at_last   = ({1'b0, tick_q} == last_tick);
    assign se_late   = ({2'b00, STROBE_EDGE} >= len);

    // Run-state sequencing: tick counter, cycle wrap, strobe and strobe-error detection.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        strobe     = 1'b0;
        cycle_done = 1'b0;
        serr_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PERFORM_TEST) begin
                    state_d = RUN;
                    tick_d  = 8'd0;
                end
            end
            RUN: begin
                if (!PERFORM_TEST) begin
                    state_d = IDLE;
                    tick_d  = 8'd0;
                end else begin
                    strobe = (tick_q == {1'b0, STROBE_EDGE});
                    if (at_last) begin
                        cycle_done = 1'b1;
                        serr_set   = se_late;
                        tick_d     = 8'd0;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = 8'd0;
            end
        endcase
    end

    // Datapath: double buffers, synchroniser, strobe snapshot and compare/accumulate.
    always_comb begin
        exp_sh_d   = EXP_LOAD      ? BUS126    : exp_sh_q;
        exp_act_d  = EXP_TRANSFER  ? exp_sh_q  : exp_act_q;
        mask_sh_d  = MASK_LOAD     ? BUS126    : mask_sh_q;
        mask_act_d = MASK_TRANSFER ? mask_sh_q : mask_act_q;
        sync1_d    = DUT_SIGNALS;
        sync2_d    = sync1_q;
        // Snapshot expected and enables at the strobe so a later transfer cannot leak in.
        cap_d      = strobe ? sync2_q              : cap_q;
        exp_snap_d = strobe ? exp_act_q            : exp_snap_q;
        en_snap_d  = strobe ? (mask_act_q & TEMPLATE) : en_snap_q;
        cmp_vld_d  = strobe;
        mism       = (cap_q ^ exp_snap_q) & en_snap_q;
        fvec_d     = fvec_q;
        fail_d     = fail_q;
        fcnt_d     = fcnt_q;
        serr_d     = serr_q | serr_set;
        if (cmp_vld_q && (|mism)) begin
            fvec_d = fvec_q | mism;
            fail_d = 1'b1;
            fcnt_d = sat_inc(fcnt_q);
        end
        if (CLEAR_FAILS) begin
            fvec_d = '0;
            fail_d = 1'b0;
            fcnt_d = '0;
            serr_d = 1'b0;
        end
    end

    // State and data registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            exp_sh_q   <= '0;
            exp_act_q  <= '0;
            mask_sh_q  <= '0;
            mask_act_q <= '0;
            cap_q      <= '0;
            exp_snap_q <= '0;
            en_snap_q  <= '0;
            cmp_vld_q  <= 1'b0;
            fvec_q     <= '0;
            fail_q     <= 1'b0;
            fcnt_q     <= '0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            exp_sh_q   <= exp_sh_d;
            exp_act_q  <= exp_act_d;
            mask_sh_q  <= mask_sh_d;
            mask_act_q <= mask_act_d;
            cap_q      <= cap_d;
            exp_snap_q <= exp_snap_d;
            en_snap_q  <= en_snap_d;
            cmp_vld_q  <= cmp_vld_d;
            fvec_q     <= fvec_d;
            fail_q     <= fail_d;
            fcnt_q     <= fcnt_d;
            serr_q     <= serr_d;
        end
    end

    assign CAPTURED    = cap_q;
    assign FAIL_VECTOR = fvec_q;
    assign FAIL        = fail_q;
    assign FAIL_COUNT  = fcnt_q;
    assign STROBE_ERR  = serr_q;
    assign CYCLE_DONE  = cycle_done;
    assign BUSY        = (state_q == RUN) || cmp_vld_q;

endmodule
